// File: rtl/phase_seq.sv
// One-hot phase sequencer feeding the control unit: per-class phase paths,
// memory/mult-div/hold stalls, and free-running cycle / retired-instruction counters.
module phase_seq #(
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic [5:0]       irfunc,
   input  logic             mem_ready,
   input  logic             hold,
   output logic [4:0]       p,
   output logic             stall,
   output logic             instr_done,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam int MDW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

   typedef enum logic [4:0] {
      P0 = 5'b00001,
      P1 = 5'b00010,
      P2 = 5'b00100,
      P3 = 5'b01000,
      P4 = 5'b10000
   } phase_t;

   typedef enum logic [2:0] {
      C_BR,
      C_ST,
      C_LD,
      C_MD,
      C_ALU
   } cls_t;

   phase_t         phase;
   phase_t         phase_nxt;
   cls_t           cls;
   logic [MDW-1:0] md_cnt;
   logic           md_busy;

   assign p = phase;

   always_comb begin
      cls = C_ALU;
      case (op)
         6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001:
            cls = C_BR;
         6'b101011, 6'b101001, 6'b101000:
            cls = C_ST;
         6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101:
            cls = C_LD;
         6'b000000: begin
            if (irfunc == 6'b011000 || irfunc == 6'b011001 ||
                irfunc == 6'b011010 || irfunc == 6'b011011)
               cls = C_MD;
         end
         default: cls = C_ALU;
      endcase
   end

   assign md_busy = (phase == P2) && (cls == C_MD) && (md_cnt != '0);

   assign stall = hold
                | (((phase == P0) || (phase == P3)) && !mem_ready)
                | md_busy;

   always_comb begin
      phase_nxt = P0;
      case (phase)
         P0: phase_nxt = mem_ready ? P1 : P0;
         P1: phase_nxt = P2;
         P2: begin
            if (md_busy)
               phase_nxt = P2;
            else if (cls == C_BR)
               phase_nxt = P0;
            else if (cls == C_ST || cls == C_LD)
               phase_nxt = P3;
            else
               phase_nxt = P4;
         end
         P3: begin
            if (!mem_ready)
               phase_nxt = P3;
            else if (cls == C_ST)
               phase_nxt = P0;
            else
               phase_nxt = P4;
         end
         P4:      phase_nxt = P0;
         default: phase_nxt = P0;
      endcase
   end

   // An out-of-range phase value decodes to P0 as next phase, so it recovers in one edge.
   assign instr_done = !stall && (phase_nxt == P0);

   always_ff @(posedge clk) begin
      if (reset) begin
         phase     <= P0;
         md_cnt    <= '0;
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (!stall) begin
            phase <= phase_nxt;
            if (instr_done)
               instr_cnt <= instr_cnt + CNT_W'(1);
            if (phase == P1 && cls == C_MD)
               md_cnt <= MDW'(MD_LAT - 1);
         end else if (!hold && md_busy) begin
            md_cnt <= md_cnt - MDW'(1);
         end
      end
   end

endmodule
